// File: rtl/div_sched_pkg.sv
// div_sched_pkg
//   Shared definitions for the divider scheduler:
//   - div_sched_state_t : scheduler state encoding
//   - drain_cycles_for(): default post-reset drain length for a given width
//   - BYPASS_Q_BIT / BYPASS_DZ : zero-divisor bypass response constants
//     (the bypass quotient is BYPASS_Q_BIT replicated over the operand width)
package div_sched_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESPOND
  } div_sched_state_t;

  // Long enough to outlast any divide the unreset divider may still have
  // in flight when reset was applied.
  function automatic int drain_cycles_for(input int bits);
    return 4 * bits + 8;
  endfunction

  localparam logic BYPASS_Q_BIT = 1'b1;
  localparam logic BYPASS_DZ    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first asserted request at
//   or above ptr, searching upward with wrap-around.
// Ports:
//   req       in  N  : request vector
//   ptr       in  IW : highest-priority index
//   en        in  1  : when low no grant is issued
//   grant     out N  : one-hot grant
//   grant_idx out IW : encoded index of the grant (0 when none)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // cand_idx[k] is the requester examined at search position k: (ptr+k) mod N.
  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_req;
  logic          found;

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && cand_req[k]) begin
        found     = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler
//   Shares one external divider between NUM_REQ requesters. Accepts one
//   request at a time (round-robin), drives start/operands to the divider,
//   waits for done and returns quotient/remainder tagged with the requester.
//   Optional feature macro: DIV_SCHED_ZERO_BYPASS_EN -- answer zero-divisor
//   requests locally (quotient all ones, remainder = dividend, rsp_dz=1)
//   without starting the divider.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/ready, req_dividend/divisor : per-requester handshake + operands
//   rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz : response bus
//   busy                             : high whenever not IDLE
//   div_start, div_dividend, div_divisor : to divider
//   div_done, div_quotient, div_remainder : from divider
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter  int BITS         = 16,
  parameter  int NUM_REQ      = 4,
  parameter  int DRAIN_CYCLES = drain_cycles_for(BITS),
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [BITS-1:0]      req_dividend [NUM_REQ],
  input  logic [BITS-1:0]      req_divisor  [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic [BITS-1:0]      rsp_quotient,
  output logic [BITS-1:0]      rsp_remainder,
  output logic                 rsp_dz,
  output logic                 busy,
  output logic                 div_start,
  output logic [BITS-1:0]      div_dividend,
  output logic [BITS-1:0]      div_divisor,
  input  logic                 div_done,
  input  logic [BITS-1:0]      div_quotient,
  input  logic [BITS-1:0]      div_remainder
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  div_sched_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [BITS-1:0]  dividend_q, dividend_d;
  logic [BITS-1:0]  divisor_q, divisor_d;
  logic [BITS-1:0]  rsp_quotient_q, rsp_quotient_d;
  logic [BITS-1:0]  rsp_remainder_q, rsp_remainder_d;
  logic             div_start_q, div_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_dz_q, rsp_dz_d;
  logic             busy_q, busy_d;
  logic             arb_en;
  logic [IW-1:0]    grant_idx;

  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    id_d            = id_q;
    rsp_id_d        = rsp_id_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dz_d        = rsp_dz_q;
    div_start_d     = 1'b0;
    rsp_valid_d     = 1'b0;

    case (state_q)
      // div_done is deliberately ignored: a divide started before reset may
      // still complete here.
      ST_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (|req_ready) begin
          id_d       = grant_idx;
          dividend_d = req_dividend[grant_idx];
          divisor_d  = req_divisor[grant_idx];
          state_d    = ST_START;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
          // Registered start must be suppressed already at accept time.
          div_start_d = (req_divisor[grant_idx] != '0);
`else
          div_start_d = 1'b1;
`endif
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
        if (divisor_q == '0) begin
          state_d         = ST_RESPOND;
          rsp_valid_d     = 1'b1;
          rsp_id_d        = id_q;
          rsp_quotient_d  = {BITS{BYPASS_Q_BIT}};
          rsp_remainder_d = dividend_q;
          rsp_dz_d        = BYPASS_DZ;
        end
`endif
      end
      ST_WAIT: begin
        if (div_done) begin
          state_d         = ST_RESPOND;
          rsp_valid_d     = 1'b1;
          rsp_id_d        = id_q;
          rsp_quotient_d  = div_quotient;
          rsp_remainder_d = div_remainder;
          rsp_dz_d        = 1'b0;
        end
      end
      ST_RESPOND: begin
        ptr_d   = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_DRAIN;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_DRAIN;
      cnt_q           <= '0;
      ptr_q           <= '0;
      id_q            <= '0;
      rsp_id_q        <= '0;
      dividend_q      <= '0;
      divisor_q       <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dz_q        <= 1'b0;
      div_start_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      busy_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
      id_q            <= id_d;
      rsp_id_q        <= rsp_id_d;
      dividend_q      <= dividend_d;
      divisor_q       <= divisor_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dz_q        <= rsp_dz_d;
      div_start_q     <= div_start_d;
      rsp_valid_q     <= rsp_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dz        = rsp_dz_q;
  assign busy          = busy_q;
  assign div_start     = div_start_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler
//   Directed bench for div_scheduler with a behavioural divider and a
//   transaction-level reference model checked every cycle.
module tb_div_scheduler;

  localparam int BITS = 16;
  localparam int N    = 4;
  localparam int IW   = $clog2(N);
  localparam int D    = 4 * BITS + 8;
  localparam int DLAT = 16;
`ifdef DIV_SCHED_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [BITS-1:0] req_dividend [N];
  logic [BITS-1:0] req_divisor  [N];
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [BITS-1:0] rsp_quotient, rsp_remainder;
  logic            rsp_dz, busy, div_start;
  logic [BITS-1:0] div_dividend, div_divisor;
  logic            div_done = 1'b0;
  logic [BITS-1:0] div_quotient = '0, div_remainder = '0;

  always #5 clk = ~clk;

  div_scheduler #(.BITS(BITS), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_count = 0;
  int start_count = 0;
  bit inject_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural divider (driven just after each edge) ----
  initial begin : divider
    int d_state = 0;
    int d_left  = 0;
    bit d_abort = 1'b0;
    bit chk_rsp_next = 1'b0;
    logic [BITS-1:0] d_a, d_b;
    forever begin
      @(posedge clk); #1;
      if (chk_rsp_next) begin
        chk("rsp_latency", rsp_valid, !d_abort);
        chk_rsp_next = 1'b0;
      end
      div_done = 1'b0;
      if (inject_done) begin
        div_done      = 1'b1;
        div_quotient  = 16'hDEAD;
        div_remainder = 16'hBEEF;
        inject_done   = 1'b0;
      end
      if (d_state != 0 && rst) d_abort = 1'b1;
      case (d_state)
        0: if (div_start) begin
          d_state = 1; start_count++; d_abort = 1'b0;
          d_a = div_dividend; d_b = div_divisor; d_left = DLAT;
        end
        default: begin
          if (!d_abort) begin
            chk("op_hold_dividend", div_dividend, d_a);
            chk("op_hold_divisor", div_divisor, d_b);
          end
          d_left--;
          if (d_left == 0) begin
            div_done      = 1'b1;
            div_quotient  = (d_b == 0) ? '1  : d_a / d_b;
            div_remainder = (d_b == 0) ? d_a : d_a % d_b;
            d_state = 0;
            chk_rsp_next = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- transaction-level reference model ---------------------
  typedef struct packed {
    logic [IW-1:0]   id;
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            dz;
  } rsp_t;
  typedef enum int {M_DRAIN, M_IDLE, M_START, M_WAIT, M_RESP} mphase_t;

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic rsp_t model_result(input int g, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    rsp_t x;
    x.id = IW'(g);
    if (b == 0) begin x.q = '1; x.r = a; x.dz = ZB; end
    else begin x.q = a / b; x.r = a % b; x.dz = 1'b0; end
    return x;
  endfunction

  initial begin : model
    mphase_t m_mode = M_DRAIN;
    bit model_on = 1'b0;
    int m_left = 0, m_ptr = 0, m_cur = 0, g;
    bit m_skip = 1'b0;
    rsp_t m_exp = '0, m_rsp = '0;
    logic [BITS-1:0] m_a = '0, m_b = '0;
    bit p_rst = 1'b0, p_done = 1'b0;
    logic [N-1:0] p_valid = '0;
    logic [BITS-1:0] p_a [N];
    logic [BITS-1:0] p_b [N];
    logic [N-1:0] exp_ready;
    forever begin
      @(negedge clk);
      // apply the edge that just passed, using inputs captured before it
      if (p_rst) begin
        model_on = 1'b1; m_mode = M_DRAIN; m_left = D; m_ptr = 0;
        m_rsp = '0; m_a = '0; m_b = '0; m_skip = 1'b0;
      end else if (model_on) begin
        case (m_mode)
          M_DRAIN: begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
          M_IDLE: begin
            g = model_grant(p_valid, m_ptr);
            if (g >= 0) begin
              m_cur = g; m_a = p_a[g]; m_b = p_b[g];
              m_exp = model_result(g, m_a, m_b);
              m_skip = ZB && (m_b == 0);
              m_mode = M_START;
            end
          end
          M_START: begin
            if (m_skip) begin m_mode = M_RESP; m_rsp = m_exp; end
            else m_mode = M_WAIT;
          end
          M_WAIT: if (p_done) begin m_mode = M_RESP; m_rsp = m_exp; end
          default: begin m_ptr = (m_cur + 1) % N; m_mode = M_IDLE; end
        endcase
      end
      p_rst = rst; p_valid = req_valid; p_done = div_done;
      for (int i = 0; i < N; i++) begin p_a[i] = req_dividend[i]; p_b[i] = req_divisor[i]; end

      if (model_on) begin
        exp_ready = '0;
        if (m_mode == M_IDLE) begin
          g = model_grant(req_valid, m_ptr);
          if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("busy", busy, m_mode != M_IDLE);
        chk("req_ready", req_ready, exp_ready);
        chk("div_start", div_start, (m_mode == M_START) && !m_skip);
        chk("rsp_valid", rsp_valid, m_mode == M_RESP);
        chk("rsp_id", rsp_id, m_rsp.id);
        chk("rsp_quotient", rsp_quotient, m_rsp.q);
        chk("rsp_remainder", rsp_remainder, m_rsp.r);
        chk("rsp_dz", rsp_dz, m_rsp.dz);
        if (m_mode inside {M_DRAIN, M_START, M_WAIT}) begin
          chk("div_dividend", div_dividend, m_a);
          chk("div_divisor", div_divisor, m_b);
        end
        if (rsp_valid) begin
          rsp_count++;
          $display("[TB] rsp id=%0d q=%0h r=%0h dz=%0b", rsp_id, rsp_quotient, rsp_remainder, rsp_dz);
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic do_req(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1; req_dividend[id] = a; req_divisor[id] = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [IW-1:0] id, output logic [BITS-1:0] q,
                          output logic [BITS-1:0] r, output logic dz);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_timeout", got, 1);
    id = rsp_id; q = rsp_quotient; r = rsp_remainder; dz = rsp_dz;
  endtask

  task automatic req_check(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic [BITS-1:0] eq, input logic [BITS-1:0] er, input logic edz);
    logic [IW-1:0] gid; logic [BITS-1:0] gq, gr; logic gdz;
    do_req(id, a, b);
    wait_rsp(gid, gq, gr, gdz);
    chk("lit_id", gid, id);
    chk("lit_quotient", gq, eq);
    chk("lit_remainder", gr, er);
    chk("lit_dz", gdz, edz);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    chk("idle_timeout", got, 1);
  endtask

  initial begin : main
    int n, s0, rc0;
    int order[$];
    int fair_exp[5] = '{0, 1, 2, 3, 0};
    logic [IW-1:0] gid; logic [BITS-1:0] gq, gr; logic gdz;
    for (int i = 0; i < N; i++) begin req_dividend[i] = '0; req_divisor[i] = '0; end

    // reset and drain, with a stale done injected mid-drain
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_quotient", rsp_quotient, 0);
        chk("reset_div_start", div_start, 0);
      end
      if (!busy) break;
      n++;
      if (n == 10) inject_done = 1'b1;
    end
    chk("drain_len", n, 72);
    chk("drain_no_rsp", rsp_count, 0);

    // spurious done while idle
    @(negedge clk); inject_done = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_spurious_no_rsp", rsp_count, 0);

    // single request and boundary operands; last served is 3 so ptr ends at 0
    req_check(2, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    req_check(0, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    req_check(1, 16'd0, 16'd3, 16'd0, 16'd0, 1'b0);
    req_check(3, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);

    // fairness: all requesters continuously valid
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_dividend[i] = BITS'(1000 + 7 * i); req_divisor[i] = BITS'(i + 3);
    end
    for (int c = 0; c < 3000 && order.size() < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("fair_count", order.size(), 5);
    for (int k = 0; k < order.size() && k < 5; k++) chk("fair_order", order[k], fair_exp[k]);
    wait_rsp(gid, gq, gr, gdz);
    chk("fair_last_id", gid, 0);
    chk("fair_last_quotient", gq, 16'd333);
    chk("fair_last_remainder", gr, 16'd1);
    wait_idle();

    // requester 1 re-requests the cycle after its own response
    req_check(1, 16'd77, 16'd8, 16'd9, 16'd5, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_dividend[1] = 16'd200; req_divisor[1] = 16'd9;
    @(negedge clk);
    chk("rerequest_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(gid, gq, gr, gdz);
    chk("rerequest_id", gid, 1);
    chk("rerequest_quotient", gq, 16'd22);
    chk("rerequest_remainder", gr, 16'd2);

    // zero divisor
    s0 = start_count;
    req_check(3, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, ZB);
    chk("zero_div_starts", start_count - s0, ZB ? 0 : 1);

    // reset while the divider is busy; stale done lands in drain
    do_req(0, 16'd300, 16'd7);
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    rc0 = rsp_count;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("abort_drain_done", busy, 0);
    chk("abort_no_rsp", rsp_count - rc0, 0);
    req_check(2, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_one_rsp", rsp_count - rc0, 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
